// File: rtl/logic_basic_queue_generic_credit.sv
// Credit-based sender feeding a downstream queue write port with no backpressure.
// The credit counter tracks free slots downstream. A returned credit that would exceed the queue depth is flagged.
module logic_basic_queue_generic_credit #(
    parameter int ADDRESS_WIDTH   = 1,
    parameter int DATA_WIDTH      = 8,
    parameter int INITIAL_CREDITS = 2 ** ADDRESS_WIDTH
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    rx_tvalid,
    output logic                    rx_tready,
    input  logic [DATA_WIDTH-1:0]   rx_tdata,
    output logic                    tx_tvalid,
    output logic [DATA_WIDTH-1:0]   tx_tdata,
    input  logic                    credit_return,
    output logic [ADDRESS_WIDTH:0]  credits,
    output logic                    credits_empty,
    output logic                    credits_full,
    output logic                    error_overflow
);

    localparam int                   MAX_CREDITS = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] MAX_C     = (ADDRESS_WIDTH+1)'(MAX_CREDITS);
    localparam logic [ADDRESS_WIDTH:0] INIT_C    = (ADDRESS_WIDTH+1)'(INITIAL_CREDITS);
    localparam logic [ADDRESS_WIDTH:0] ONE_C     = (ADDRESS_WIDTH+1)'(1);

    // Handshake: a word moves when rx_tvalid and rx_tready are both high on a
    // rising edge. rx_tready depends only on the credit register, so it never
    // combinationally follows rx_tvalid or credit_return. tx_tvalid is a
    // one-cycle write strobe into the downstream queue and cannot be stalled.
    logic                   transfer;
    logic [ADDRESS_WIDTH:0] credits_next;
    logic                   overflow_event;

    assign rx_tready     = (credits != '0);
    assign transfer      = rx_tvalid && rx_tready;
    assign credits_empty = (credits == '0);
    assign credits_full  = (credits == MAX_C);

    always_comb begin
        credits_next   = credits;
        overflow_event = 1'b0;
        if (transfer && !credit_return) begin
            credits_next = credits - ONE_C;
        end else if (credit_return && !transfer) begin
            // At full depth the return is bogus: saturate and flag it.
            if (credits == MAX_C) begin
                overflow_event = 1'b1;
            end else begin
                credits_next = credits + ONE_C;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            credits        <= INIT_C;
            error_overflow <= 1'b0;
        end else begin
            credits <= credits_next;
            if (overflow_event) begin
                error_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tx_tvalid <= 1'b0;
            tx_tdata  <= '0;
        end else begin
            tx_tvalid <= transfer;
            if (transfer) begin
                tx_tdata <= rx_tdata;
            end
        end
    end

endmodule

// File: tb/tb_logic_basic_queue_generic_credit.sv
// Bench for the credit sender at ADDRESS_WIDTH=2 with a cycle-level credit model.
module tb_logic_basic_queue_generic_credit;

    localparam int AW   = 2;
    localparam int DW   = 8;
    localparam int MAXC = 4;

    logic          aclk;
    logic          areset;
    logic          rx_tvalid;
    logic          rx_tready;
    logic [DW-1:0] rx_tdata;
    logic          tx_tvalid;
    logic [DW-1:0] tx_tdata;
    logic          credit_return;
    logic [AW:0]   credits;
    logic          credits_empty;
    logic          credits_full;
    logic          error_overflow;

    int vectors;
    int miscompares;

    // reference model
    int            m_credits;
    bit            m_tx_valid;
    logic [DW-1:0] m_tx_data;
    bit            m_ovf;
    logic [DW-1:0] exp_q[$];

    logic_basic_queue_generic_credit #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .rx_tvalid(rx_tvalid),
        .rx_tready(rx_tready),
        .rx_tdata(rx_tdata),
        .tx_tvalid(tx_tvalid),
        .tx_tdata(tx_tdata),
        .credit_return(credit_return),
        .credits(credits),
        .credits_empty(credits_empty),
        .credits_full(credits_full),
        .error_overflow(error_overflow)
    );

    // clock / reset
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running, want done");
        $fatal(1);
    end

    task automatic model_reset();
        m_credits  = MAXC;
        m_tx_valid = 0;
        m_tx_data  = '0;
        m_ovf      = 0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        areset        = 1'b1;
        rx_tvalid     = 1'b0;
        credit_return = 1'b0;
        model_reset();
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    // One clock: the model applies the credit rules to the inputs seen at the edge.
    task automatic tick();
        bit xfer;
        xfer = rx_tvalid && (m_credits != 0);
        @(posedge aclk);
        if (!areset) begin
            m_tx_valid = xfer;
            if (xfer) begin
                m_tx_data = rx_tdata;
                exp_q.push_back(rx_tdata);
            end
            if (xfer && !credit_return) m_credits = m_credits - 1;
            else if (!xfer && credit_return) begin
                if (m_credits == MAXC) m_ovf = 1;
                else m_credits = m_credits + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        areset        = 1'b1;
        rx_tvalid     = 1'b0;
        rx_tdata      = '0;
        credit_return = 1'b1;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        vectors++; if (credits !== 3'd4) begin miscompares++; $display("FAIL reset_credits: got %0d want 4", credits); end
        vectors++; if (credits_full !== 1'b1) begin miscompares++; $display("FAIL reset_full: got %b want 1", credits_full); end
        vectors++; if (credits_empty !== 1'b0) begin miscompares++; $display("FAIL reset_empty: got %b want 0", credits_empty); end
        vectors++; if (rx_tready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", rx_tready); end
        vectors++; if (tx_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b want 0", tx_tvalid); end
        vectors++; if (tx_tdata !== 8'h00) begin miscompares++; $display("FAIL reset_tdata: got %h want 00", tx_tdata); end
        vectors++; if (error_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", error_overflow); end
        credit_return = 1'b0;
        areset        = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] words [5];
        int idx;
        int pulses;
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        apply_reset();
        idx = 0;
        pulses = 0;
        rx_tvalid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            rx_tdata = words[idx];
            tick();
            if (m_tx_valid) idx++;
            if (tx_tvalid === 1'b1) begin
                vectors++;
                if (pulses > 3 || tx_tdata !== words[pulses]) begin
                    miscompares++;
                    $display("FAIL fill_data[%0d]: got %h want %h", pulses, tx_tdata, (pulses < 5) ? words[pulses] : 8'hxx);
                end
                pulses++;
            end
            vectors++; if (credits !== 3'(m_credits)) begin miscompares++; $display("FAIL fill_credits c%0d: got %0d want %0d", c, credits, m_credits); end
        end
        vectors++; if (pulses !== 4) begin miscompares++; $display("FAIL fill_pulses: got %0d want 4", pulses); end
        vectors++; if (credits !== 3'd0) begin miscompares++; $display("FAIL fill_credits_end: got %0d want 0", credits); end
        vectors++; if (rx_tready !== 1'b0) begin miscompares++; $display("FAIL fill_ready: got %b want 0", rx_tready); end
        vectors++; if (credits_empty !== 1'b1) begin miscompares++; $display("FAIL fill_empty: got %b want 1", credits_empty); end
        vectors++; if (tx_tdata !== 8'h44) begin miscompares++; $display("FAIL fill_hold: got %h want 44", tx_tdata); end
    endtask

    task automatic test_credit_from_zero();
        rx_tvalid     = 1'b1;
        rx_tdata      = 8'h55;
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        vectors++; if (credits !== 3'd1) begin miscompares++; $display("FAIL zero_credits: got %0d want 1", credits); end
        vectors++; if (rx_tready !== 1'b1) begin miscompares++; $display("FAIL zero_ready: got %b want 1", rx_tready); end
        vectors++; if (tx_tvalid !== 1'b0) begin miscompares++; $display("FAIL zero_early_tx: got %b want 0", tx_tvalid); end
        tick();
        vectors++; if (tx_tvalid !== 1'b1) begin miscompares++; $display("FAIL zero_tx: got %b want 1", tx_tvalid); end
        vectors++; if (tx_tdata !== 8'h55) begin miscompares++; $display("FAIL zero_tdata: got %h want 55", tx_tdata); end
        vectors++; if (credits !== 3'd0) begin miscompares++; $display("FAIL zero_credits_end: got %0d want 0", credits); end
        rx_tvalid = 1'b0;
        tick();
        vectors++; if (tx_tvalid !== 1'b0) begin miscompares++; $display("FAIL zero_tx_end: got %b want 0", tx_tvalid); end
        vectors++; if (tx_tdata !== 8'h55) begin miscompares++; $display("FAIL zero_hold: got %h want 55", tx_tdata); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        apply_reset();
        rx_tvalid = 1'b1;
        repeat (2) begin
            rx_tdata = DW'($urandom);
            tick();
        end
        vectors++; if (credits !== 3'd2) begin miscompares++; $display("FAIL b2b_setup: got %0d want 2", credits); end
        pulses = 0;
        credit_return = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rx_tdata = DW'($urandom);
            tick();
            if (tx_tvalid === 1'b1) pulses++;
            vectors++; if (tx_tdata !== m_tx_data) begin miscompares++; $display("FAIL b2b_data c%0d: got %h want %h", c, tx_tdata, m_tx_data); end
            vectors++; if (credits !== 3'd2) begin miscompares++; $display("FAIL b2b_credits c%0d: got %0d want 2", c, credits); end
        end
        vectors++; if (pulses !== 10) begin miscompares++; $display("FAIL b2b_pulses: got %0d want 10", pulses); end
        credit_return = 1'b0;
        rx_tvalid     = 1'b0;
    endtask

    task automatic test_overflow();
        apply_reset();
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        vectors++; if (credits !== 3'd4) begin miscompares++; $display("FAIL ovf_credits: got %0d want 4", credits); end
        vectors++; if (error_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", error_overflow); end
        rx_tvalid = 1'b1;
        rx_tdata  = 8'hA5;
        repeat (3) tick();
        rx_tvalid = 1'b0;
        vectors++; if (error_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", error_overflow); end
        vectors++; if (credits !== 3'd1) begin miscompares++; $display("FAIL ovf_after_xfer: got %0d want 1", credits); end

        apply_reset();
        rx_tvalid     = 1'b1;
        rx_tdata      = 8'h3C;
        credit_return = 1'b1;
        tick();
        rx_tvalid     = 1'b0;
        credit_return = 1'b0;
        vectors++; if (error_overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_coincide: got %b want 0", error_overflow); end
        vectors++; if (credits !== 3'd4) begin miscompares++; $display("FAIL ovf_coincide_credits: got %0d want 4", credits); end
        vectors++; if (tx_tvalid !== 1'b1 || tx_tdata !== 8'h3C) begin miscompares++; $display("FAIL ovf_coincide_tx: got %b/%h want 1/3c", tx_tvalid, tx_tdata); end
    endtask

    task automatic test_reset_mid_transfer();
        apply_reset();
        rx_tvalid = 1'b1;
        rx_tdata  = 8'h77;
        repeat (3) tick();
        rx_tvalid = 1'b0;
        vectors++; if (tx_tvalid !== 1'b1 || credits !== 3'd1) begin miscompares++; $display("FAIL mid_setup: got %b/%0d want 1/1", tx_tvalid, credits); end
        #1;
        areset        = 1'b1;
        credit_return = 1'b1;
        model_reset();
        #1;
        vectors++; if (tx_tvalid !== 1'b0) begin miscompares++; $display("FAIL mid_tvalid: got %b want 0", tx_tvalid); end
        repeat (2) @(posedge aclk);
        #2;
        credit_return = 1'b0;
        areset        = 1'b0;
        #1;
        vectors++; if (credits !== 3'd4) begin miscompares++; $display("FAIL mid_credits: got %0d want 4", credits); end
        vectors++; if (error_overflow !== 1'b0) begin miscompares++; $display("FAIL mid_ovf: got %b want 0", error_overflow); end
        rx_tvalid = 1'b1;
        rx_tdata  = 8'h99;
        tick();
        rx_tvalid = 1'b0;
        vectors++; if (tx_tvalid !== 1'b1 || tx_tdata !== 8'h99) begin miscompares++; $display("FAIL first_edge_tx: got %b/%h want 1/99", tx_tvalid, tx_tdata); end
        vectors++; if (credits !== 3'd3) begin miscompares++; $display("FAIL first_edge_credits: got %0d want 3", credits); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_word;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            rx_tvalid     = ($urandom_range(0, 3) != 0);
            credit_return = ($urandom_range(0, 2) == 0);
            rx_tdata      = DW'($urandom);
            vectors++; if (rx_tready !== (m_credits != 0)) begin miscompares++; $display("FAIL rnd_ready c%0d: got %b want %b", c, rx_tready, m_credits != 0); end
            tick();
            vectors++; if (credits !== 3'(m_credits)) begin miscompares++; $display("FAIL rnd_credits c%0d: got %0d want %0d", c, credits, m_credits); end
            vectors++; if (credits_empty !== (m_credits == 0) || credits_full !== (m_credits == MAXC)) begin miscompares++; $display("FAIL rnd_flags c%0d: got e%b f%b want e%b f%b", c, credits_empty, credits_full, m_credits == 0, m_credits == MAXC); end
            vectors++; if (error_overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, error_overflow, m_ovf); end
            vectors++; if (tx_tvalid !== m_tx_valid) begin miscompares++; $display("FAIL rnd_tvalid c%0d: got %b want %b", c, tx_tvalid, m_tx_valid); end
            if (m_tx_valid && exp_q.size() > 0) begin
                exp_word = exp_q.pop_front();
                vectors++; if (tx_tdata !== exp_word) begin miscompares++; $display("FAIL rnd_data c%0d: got %h want %h", c, tx_tdata, exp_word); end
            end else begin
                vectors++; if (tx_tdata !== m_tx_data) begin miscompares++; $display("FAIL rnd_hold c%0d: got %h want %h", c, tx_tdata, m_tx_data); end
            end
        end
        rx_tvalid     = 1'b0;
        credit_return = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_fill_drain();
        test_credit_from_zero();
        test_back_to_back();
        test_overflow();
        test_reset_mid_transfer();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
